ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide execute unit for the RV32M/RV64M ops.
//  Sits beside the single-cycle EX ALU and is selected when the decoder flags an M-extension op.
//  Iterative shift-add multiplier and restoring divider, 1 bit per cycle.
//  Holds the pipeline via stall_req_o until the result is ready.
// PARAMETERS
//  XLEN      32  operand/result width (32 or 64)
//  RADDR_W   5   destination register address width
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        reset, synchronous, active-high
//  flush        in   1        pipeline flush; aborts any operation in flight
//  start_i      in   1        valid M op presented this cycle
//  op_i         in   3        funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  rs1_i        in   XLEN     operand 1
//  rs2_i        in   XLEN     operand 2
//  wd_i         in   RADDR_W  destination register
//  wreg_i       in   1        write-enable for destination
//  busy_o       out  1        unit not IDLE
//  stall_req_o  out  1        request EX stall to the pipeline controller
//  done_o       out  1        one-cycle pulse; result_o/wd_o/wreg_o valid
//  result_o     out  XLEN     result
//  wd_o         out  RADDR_W  captured wd_i
//  wreg_o       out  1        captured wreg_i, qualified by done_o
// BEHAVIOUR
//  - Reset: state=IDLE; busy_o, stall_req_o, done_o, wreg_o = 0; result_o = 0; wd_o = 0; counter = 0.
//  - FSM: IDLE -> CALC -> DONE -> IDLE.
//    IDLE->CALC on start_i && !flush. At that edge capture op, |rs1|, |rs2|, sign flags, wd_i, wreg_i.
//    CALC runs exactly XLEN cycles (counter 0..XLEN-1), then DONE.
//    DONE lasts 1 cycle with done_o = 1, then IDLE.
//  - Latency: start sampled at edge k; done_o high during cycle k+XLEN+1.
//  - Fast path, IDLE->DONE directly (done_o at k+1):
//    - divisor==0: DIV/DIVU -> all ones; REM/REMU -> rs1.
//    - signed overflow, DIV/REM of -2^(XLEN-1) by -1: DIV -> -2^(XLEN-1); REM -> 0.
//  - Signedness:
//    - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. DIV/REM: signed.
//    - All others unsigned.
//    - Signed operands are converted to magnitudes. The 2*XLEN product or quotient/remainder is negated in DONE:
//      product if sign1^sign2; quotient if sign1^sign2; remainder takes the sign of rs1.
//  - Result select: MUL -> low XLEN of product; MULH* -> high XLEN; DIV* -> quotient; REM* -> remainder.
//  - stall_req_o = (IDLE && start_i && !flush) || CALC. Deasserted in DONE so the pipeline advances on the done_o cycle.
//  - busy_o = (state != IDLE).
//  - start_i while busy_o=1 is ignored; no queueing.
//  - flush in any state: next state IDLE, done_o stays 0, wreg_o stays 0.
//    flush has priority over a simultaneous start_i and over DONE.
//  - rst mid-operation: same as reset values next cycle; partial result discarded.
//  - wreg_o = captured wreg_i only while done_o=1, else 0. result_o/wd_o hold their last value between ops.
// TESTING
//  - MUL 7 * 0xFFFFFFFD -> result_o=0xFFFFFFEB, done_o exactly at k+33, stall_req_o high k..k+32.
//  - MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//  - MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  - DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both with done_o at k+1.
//  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
//  - REM 0xFFFFFFF9 (-7) % 2 -> 0xFFFFFFFF. DIV -> 0xFFFFFFFD.
//  - flush at cycle k+10 of a DIVU -> IDLE at k+11, no done_o.
//    start_i pulsed at k+5 while busy is ignored. XLEN=64 rerun of MUL case.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide execute unit.
// Shift-add multiplier and restoring divider, one bit per cycle, sharing one
// accumulator/shift datapath. Holds the pipeline via stall_req_o until the result is ready.
module ex_muldiv_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [XLEN-1:0]    rs1_i,
  input  logic [XLEN-1:0]    rs2_i,
  input  logic [RADDR_W-1:0] wd_i,
  input  logic               wreg_i,
  output logic               busy_o,
  output logic               stall_req_o,
  output logic               done_o,
  output logic [XLEN-1:0]    result_o,
  output logic [RADDR_W-1:0] wd_o,
  output logic               wreg_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               sgn1_q, sgn1_d, sgn2_q, sgn2_d;
  logic [XLEN-1:0]    acc_q, acc_d;
  logic [XLEN-1:0]    lo_q, lo_d;
  logic [XLEN-1:0]    opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RADDR_W-1:0] wd_cap_q, wd_cap_d;
  logic               wreg_cap_q, wreg_cap_d;
  logic               done_q, done_d;
  logic               wreg_q, wreg_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic [RADDR_W-1:0] wd_q, wd_d;

  // Operand decode at issue: signedness, magnitudes and fast-path detection
  logic            rs1_neg, rs2_neg, div0, ovf;
  logic [XLEN-1:0] mag1, mag2, fast_res;

  always_comb begin
    rs1_neg  = rs1_i[XLEN-1] & (op_i == 3'd1 || op_i == 3'd2 || op_i == 3'd4 || op_i == 3'd6);
    rs2_neg  = rs2_i[XLEN-1] & (op_i == 3'd1 || op_i == 3'd4 || op_i == 3'd6);
    mag1     = rs1_neg ? (XLEN'(0) - rs1_i) : rs1_i;
    mag2     = rs2_neg ? (XLEN'(0) - rs2_i) : rs2_i;
    div0     = op_i[2] && (rs2_i == '0);
    ovf      = (op_i == 3'd4 || op_i == 3'd6) && (rs1_i == SMIN) && (rs2_i == '1);
    fast_res = '0;
    if (div0)     fast_res = op_i[1] ? rs1_i : '1;
    else if (ovf) fast_res = op_i[1] ? '0 : SMIN;
  end

  // One iteration of the shared multiply/divide datapath
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] step_acc, step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[XLEN];
    if (op_q[2]) begin
      step_acc = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      step_lo  = {lo_q[XLEN-2:0], div_ge};
    end else begin
      step_acc = mul_sum[XLEN:1];
      step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fix-up and result select from the final iteration's values
  logic [PW-1:0]   prod, prod_s;
  logic [XLEN-1:0] quot_s, rem_s, calc_res;

  always_comb begin
    prod   = {step_acc, step_lo};
    prod_s = (sgn1_q ^ sgn2_q) ? (PW'(0) - prod) : prod;
    quot_s = (sgn1_q ^ sgn2_q) ? (XLEN'(0) - step_lo) : step_lo;
    rem_s  = sgn1_q ? (XLEN'(0) - step_acc) : step_acc;
    case (op_q)
      3'd0:             calc_res = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: calc_res = prod_s[PW-1:XLEN];
      3'd4, 3'd5:       calc_res = quot_s;
      default:          calc_res = rem_s;
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sgn1_d     = sgn1_q;
    sgn2_d     = sgn2_q;
    acc_d      = acc_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    wd_cap_d   = wd_cap_q;
    wreg_cap_d = wreg_cap_q;
    done_d     = 1'b0;
    wreg_d     = 1'b0;
    result_d   = result_q;
    wd_d       = wd_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d       = op_i;
          sgn1_d     = rs1_neg;
          sgn2_d     = rs2_neg;
          wd_cap_d   = wd_i;
          wreg_cap_d = wreg_i;
          cnt_d      = '0;
          if (div0 || ovf) begin
            state_d  = S_DONE;
            result_d = fast_res;
            wd_d     = wd_i;
            wreg_d   = wreg_i;
            done_d   = 1'b1;
          end else begin
            state_d = S_CALC;
            acc_d   = '0;
            lo_d    = op_i[2] ? mag1 : mag2;
            opnd_d  = op_i[2] ? mag2 : mag1;
          end
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = calc_res;
          wd_d     = wd_cap_q;
          wreg_d   = wreg_cap_q;
          done_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Flush wins over start and completion; the visible result is left untouched
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      done_d   = 1'b0;
      wreg_d   = 1'b0;
      result_d = result_q;
      wd_d     = wd_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      sgn1_q     <= 1'b0;
      sgn2_q     <= 1'b0;
      acc_q      <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      wd_cap_q   <= '0;
      wreg_cap_q <= 1'b0;
      done_q     <= 1'b0;
      wreg_q     <= 1'b0;
      result_q   <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sgn1_q     <= sgn1_d;
      sgn2_q     <= sgn2_d;
      acc_q      <= acc_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      cnt_q      <= cnt_d;
      wd_cap_q   <= wd_cap_d;
      wreg_cap_q <= wreg_cap_d;
      done_q     <= done_d;
      wreg_q     <= wreg_d;
      result_q   <= result_d;
      wd_q       <= wd_d;
    end
  end

  // Stall covers the issue cycle so the op is held until the unit has taken it
  assign stall_req_o = ((state_q == S_IDLE) && start_i && !flush) || (state_q == S_CALC);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign wreg_o      = wreg_q;
  assign result_o    = result_q;
  assign wd_o        = wd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (XLEN=32 and XLEN=64 instances).
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, start32, start64, wreg;
  logic [2:0]  op;
  logic [63:0] rs1, rs2;
  logic [4:0]  wd;

  logic        busy32, stall32, done32, wreg32;
  logic [31:0] res32;
  logic [4:0]  wd32;
  logic        busy64, stall64, done64, wreg64;
  logic [63:0] res64;
  logic [4:0]  wd64;

  int n_assert = 0;
  int n_fail   = 0;

  ex_muldiv_unit #(.XLEN(32), .RADDR_W(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .start_i(start32), .op_i(op),
    .rs1_i(rs1[31:0]), .rs2_i(rs2[31:0]), .wd_i(wd), .wreg_i(wreg),
    .busy_o(busy32), .stall_req_o(stall32), .done_o(done32),
    .result_o(res32), .wd_o(wd32), .wreg_o(wreg32)
  );

  ex_muldiv_unit #(.XLEN(64), .RADDR_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .start_i(start64), .op_i(op),
    .rs1_i(rs1), .rs2_i(rs2), .wd_i(wd), .wreg_i(wreg),
    .busy_o(busy64), .stall_req_o(stall64), .done_o(done64),
    .result_o(res64), .wd_o(wd64), .wreg_o(wreg64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at the next edge, wait (bounded) for done_o, check latency/result/handshake.
  // poke > 0 re-pulses start with different operands in that cycle while the unit is busy.
  task automatic run_op(input string tag, input bit w64, input logic [2:0] o,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] d,
                        input int exp_lat, input logic [63:0] exp, input int poke);
    int   lat;
    int   stall_low;
    logic cur_done;
    op = o; rs1 = a; rs2 = b; wd = d; wreg = 1'b1;
    if (w64) start64 = 1'b1; else start32 = 1'b1;
    #1;
    chk({tag, "/stall_issue"}, w64 ? stall64 : stall32, 1);
    lat = 0;
    stall_low = 0;
    cur_done = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      start32 = 1'b0; start64 = 1'b0; rs1 = a;
      if (lat == poke) begin
        rs1 = ~a; wd = ~d;
        if (w64) start64 = 1'b1; else start32 = 1'b1;
      end
      cur_done = w64 ? done64 : done32;
      if (!cur_done && !(w64 ? stall64 : stall32)) stall_low++;
    end while (!cur_done && lat < 200);
    start32 = 1'b0; start64 = 1'b0;
    chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "/result"}, w64 ? res64 : {32'h0, res32}, exp);
    chk({tag, "/wreg_o"}, w64 ? wreg64 : wreg32, 1);
    chk({tag, "/wd_o"}, w64 ? wd64 : wd32, d);
    chk({tag, "/stall_done"}, w64 ? stall64 : stall32, 0);
    if (exp_lat > 1) chk({tag, "/stall_calc"}, 64'(stall_low), 0);
    @(posedge clk); #1;
    chk({tag, "/done_drop"}, w64 ? done64 : done32, 0);
    chk({tag, "/wreg_drop"}, w64 ? wreg64 : wreg32, 0);
    chk({tag, "/busy_idle"}, w64 ? busy64 : busy32, 0);
    chk({tag, "/result_hold"}, w64 ? res64 : {32'h0, res32}, exp);
  endtask

  initial begin
    int   cyc;
    logic saw_done;
    rst = 1'b1; flush = 1'b0; start32 = 1'b0; start64 = 1'b0;
    op = 3'd0; rs1 = '0; rs2 = '0; wd = '0; wreg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/busy", busy32, 0);
    chk("reset/stall", stall32, 0);
    chk("reset/done", done32, 0);
    chk("reset/result", res32, 0);
    chk("reset/wd", wd32, 0);
    chk("reset/wreg", wreg32, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("mul",      0, 3'd0, 64'h7,        64'hFFFFFFFD, 5'd3,  33, 64'hFFFFFFEB, -1);
    run_op("mulh",     0, 3'd1, 64'h80000000, 64'h80000000, 5'd4,  33, 64'h40000000, -1);
    run_op("mulhu",    0, 3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd5,  33, 64'hFFFFFFFE, -1);
    run_op("mulhsu",   0, 3'd2, 64'hFFFFFFFF, 64'h2,        5'd6,  33, 64'hFFFFFFFF, -1);
    run_op("div_by0",  0, 3'd4, 64'h5,        64'h0,        5'd7,  1,  64'hFFFFFFFF, -1);
    run_op("remu_by0", 0, 3'd7, 64'h5,        64'h0,        5'd8,  1,  64'h5,        -1);
    run_op("div_ovf",  0, 3'd4, 64'h80000000, 64'hFFFFFFFF, 5'd9,  1,  64'h80000000, -1);
    run_op("rem_ovf",  0, 3'd6, 64'h80000000, 64'hFFFFFFFF, 5'd10, 1,  64'h0,        -1);
    run_op("rem_neg",  0, 3'd6, 64'hFFFFFFF9, 64'h2,        5'd11, 33, 64'hFFFFFFFF, -1);
    run_op("div_neg",  0, 3'd4, 64'hFFFFFFF9, 64'h2,        5'd12, 33, 64'hFFFFFFFD, -1);
    run_op("divu_ign", 0, 3'd5, 64'd100,      64'd7,        5'd13, 33, 64'd14,       5);

    // Flush at cycle k+10 of a DIVU, with an ignored start at k+5
    op = 3'd5; rs1 = 64'd1000; rs2 = 64'd3; wd = 5'd14; wreg = 1'b1;
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      start32 = (cyc == 5);
      @(posedge clk); #1;
      cyc++;
    end
    start32 = 1'b0;
    chk("flush/busy_before", busy32, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush/busy_after", busy32, 0);
    chk("flush/stall_after", stall32, 0);
    chk("flush/result_hold", res32, 14);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32 || wreg32) saw_done = 1'b1;
    end
    chk("flush/no_done", saw_done, 0);

    // Flush has priority over a simultaneous start
    op = 3'd0; rs1 = 64'h3; rs2 = 64'h3; start32 = 1'b1; flush = 1'b1;
    #1;
    chk("start_flush/stall", stall32, 0);
    @(posedge clk); #1;
    start32 = 1'b0; flush = 1'b0;
    chk("start_flush/busy", busy32, 0);
    chk("start_flush/done", done32, 0);

    // Reset mid-operation
    op = 3'd0; rs1 = 64'h9; rs2 = 64'h9; wd = 5'd20; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid/busy_before", busy32, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid/busy", busy32, 0);
    chk("rst_mid/done", done32, 0);
    chk("rst_mid/result", res32, 0);
    chk("rst_mid/wd", wd32, 0);
    @(posedge clk); #1;

    run_op("mul64",   1, 3'd0, 64'h7,               64'hFFFFFFFD,         5'd21, 65, 64'h00000006FFFFFFEB, -1);
    run_op("mulhu64", 1, 3'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd22, 65, 64'hFFFFFFFFFFFFFFFE, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
